// File: rtl/alu_ex_stage.sv
// Pipelined execute stage: operand forwarding, immediate mux, ALU control decode and a
// single-entry valid/ready output register, plus a saturating arithmetic-overflow counter.

module alu32 (
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  logic [3:0]  ctrl,
  output logic [31:0] result,
  output logic        zero,
  output logic        overflow
);

  logic [31:0] sum;
  logic [31:0] diff;
  logic        add_ovf;
  logic        sub_ovf;
  logic        set_lt;

  assign sum     = a + b;
  assign diff    = a - b;
  assign add_ovf = (a[31] == b[31]) && (sum[31] != a[31]);
  assign sub_ovf = (a[31] != b[31]) && (diff[31] != a[31]);
  // Signed less-than from the subtraction: sign bit corrected by overflow.
  assign set_lt  = diff[31] ^ sub_ovf;

  always_comb begin
    result   = '0;
    overflow = 1'b0;
    case (ctrl)
      4'b0000: result = a & b;
      4'b0001: result = a | b;
      4'b0010: begin
        result   = sum;
        overflow = add_ovf;
      end
      4'b0110: begin
        result   = diff;
        overflow = sub_ovf;
      end
      4'b0111: begin
        result   = {31'b0, set_lt};
        overflow = sub_ovf;
      end
      4'b1100: result = ~(a | b);
      default: result = '0;
    endcase
  end

  assign zero = (result == 32'd0);

endmodule

module alu_ex_stage #(
  parameter int unsigned CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [31:0]      rs1_data,
  input  logic [31:0]      rs2_data,
  input  logic [31:0]      imm,
  input  logic             alu_src,
  input  logic [1:0]       alu_op,
  input  logic [5:0]       funct,
  input  logic [4:0]       rd,
  input  logic [1:0]       fwd_a,
  input  logic [1:0]       fwd_b,
  input  logic [31:0]      mem_fwd,
  input  logic [31:0]      wb_fwd,
  input  logic             flush,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [31:0]      out_result,
  output logic             out_zero,
  output logic             out_overflow,
  output logic             out_illegal,
  output logic [4:0]       out_rd,
  output logic [CNT_W-1:0] ovf_count
);

  localparam logic [3:0] CtrlAnd = 4'b0000;
  localparam logic [3:0] CtrlOr  = 4'b0001;
  localparam logic [3:0] CtrlAdd = 4'b0010;
  localparam logic [3:0] CtrlSub = 4'b0110;
  localparam logic [3:0] CtrlSlt = 4'b0111;
  localparam logic [3:0] CtrlNor = 4'b1100;

  localparam logic [5:0] FnAdd = 6'b100000;
  localparam logic [5:0] FnSub = 6'b100010;
  localparam logic [5:0] FnAnd = 6'b100100;
  localparam logic [5:0] FnOr  = 6'b100101;
  localparam logic [5:0] FnSlt = 6'b101010;
  localparam logic [5:0] FnNor = 6'b100111;

  logic [31:0] op_a;
  logic [31:0] op_b_fwd;
  logic [31:0] op_b;
  logic [3:0]  alu_ctrl;
  logic        illegal;
  logic [31:0] alu_result;
  logic        alu_zero;
  logic        alu_ovf;
  logic        ovf_masked;
  logic        accept;
  logic        cnt_full;

  logic             valid_q, valid_d;
  logic [31:0]      result_q;
  logic             zero_q;
  logic             ovf_q;
  logic             illegal_q;
  logic [4:0]       rd_q;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    unique case (fwd_a)
      2'b01:   op_a = mem_fwd;
      2'b10:   op_a = wb_fwd;
      default: op_a = rs1_data;
    endcase
  end

  always_comb begin
    unique case (fwd_b)
      2'b01:   op_b_fwd = mem_fwd;
      2'b10:   op_b_fwd = wb_fwd;
      default: op_b_fwd = rs2_data;
    endcase
  end

  // The immediate is never a forwarding target, so it overrides after the forward mux.
  assign op_b = alu_src ? imm : op_b_fwd;

  always_comb begin
    alu_ctrl = CtrlAdd;
    illegal  = 1'b0;
    unique case (alu_op)
      2'b00: alu_ctrl = CtrlAdd;
      2'b01: alu_ctrl = CtrlSub;
      2'b11: alu_ctrl = CtrlOr;
      default: begin
        case (funct)
          FnAdd:   alu_ctrl = CtrlAdd;
          FnSub:   alu_ctrl = CtrlSub;
          FnAnd:   alu_ctrl = CtrlAnd;
          FnOr:    alu_ctrl = CtrlOr;
          FnSlt:   alu_ctrl = CtrlSlt;
          FnNor:   alu_ctrl = CtrlNor;
          default: begin
            alu_ctrl = CtrlAdd;
            illegal  = 1'b1;
          end
        endcase
      end
    endcase
  end

  alu32 u_alu (
    .a        (op_a),
    .b        (op_b),
    .ctrl     (alu_ctrl),
    .result   (alu_result),
    .zero     (alu_zero),
    .overflow (alu_ovf)
  );

  // slt's internal subtraction overflow is not an architectural overflow.
  assign ovf_masked = alu_ovf && ((alu_ctrl == CtrlAdd) || (alu_ctrl == CtrlSub));

  assign in_ready = !valid_q || out_ready;
  assign accept   = in_valid && in_ready && !flush;
  assign cnt_full = &cnt_q;

  always_comb begin
    valid_d = valid_q;
    if (flush) begin
      valid_d = 1'b0;
    end else if (accept) begin
      valid_d = 1'b1;
    end else if (out_ready) begin
      valid_d = 1'b0;
    end
  end

  always_comb begin
    cnt_d = cnt_q;
    if (accept && ovf_masked && !cnt_full) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q <= 1'b0;
      cnt_q   <= '0;
    end else begin
      valid_q <= valid_d;
      cnt_q   <= cnt_d;
    end
  end

  // Payload only moves on accept; it keeps its last value after a drain or flush.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      result_q  <= '0;
      zero_q    <= 1'b0;
      ovf_q     <= 1'b0;
      illegal_q <= 1'b0;
      rd_q      <= '0;
    end else if (accept) begin
      result_q  <= alu_result;
      zero_q    <= alu_zero;
      ovf_q     <= ovf_masked;
      illegal_q <= illegal;
      rd_q      <= rd;
    end
  end

  assign out_valid    = valid_q;
  assign out_result   = result_q;
  assign out_zero     = zero_q;
  assign out_overflow = ovf_q;
  assign out_illegal  = illegal_q;
  assign out_rd       = rd_q;
  assign ovf_count    = cnt_q;

endmodule

// File: tb/tb_alu_ex_stage.sv
// Bench for alu_ex_stage: directed vector table, handshake corner sequences and random
// traffic, all scored against an arithmetic reference model of the execute stage.

module tb_alu_ex_stage;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic [31:0] rs1_data, rs2_data, imm, mem_fwd, wb_fwd;
  logic        alu_src;
  logic [1:0]  alu_op, fwd_a, fwd_b;
  logic [5:0]  funct;
  logic [4:0]  rd;
  logic        flush;
  logic        out_ready;

  logic        in_ready, out_valid, out_zero, out_overflow, out_illegal;
  logic [31:0] out_result;
  logic [4:0]  out_rd;
  logic [15:0] ovf_count;

  logic        s_in_ready, s_out_valid, s_out_zero, s_out_overflow, s_out_illegal;
  logic [31:0] s_out_result;
  logic [4:0]  s_out_rd;
  logic [1:0]  s_ovf_count;

  always #5 clk = ~clk;

  alu_ex_stage #(.CNT_W(16)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .rs1_data(rs1_data), .rs2_data(rs2_data), .imm(imm), .alu_src(alu_src),
    .alu_op(alu_op), .funct(funct), .rd(rd), .fwd_a(fwd_a), .fwd_b(fwd_b),
    .mem_fwd(mem_fwd), .wb_fwd(wb_fwd), .flush(flush), .out_valid(out_valid),
    .out_ready(out_ready), .out_result(out_result), .out_zero(out_zero),
    .out_overflow(out_overflow), .out_illegal(out_illegal), .out_rd(out_rd),
    .ovf_count(ovf_count)
  );

  alu_ex_stage #(.CNT_W(2)) dut_sat (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(s_in_ready),
    .rs1_data(rs1_data), .rs2_data(rs2_data), .imm(imm), .alu_src(alu_src),
    .alu_op(alu_op), .funct(funct), .rd(rd), .fwd_a(fwd_a), .fwd_b(fwd_b),
    .mem_fwd(mem_fwd), .wb_fwd(wb_fwd), .flush(flush), .out_valid(s_out_valid),
    .out_ready(out_ready), .out_result(s_out_result), .out_zero(s_out_zero),
    .out_overflow(s_out_overflow), .out_illegal(s_out_illegal), .out_rd(s_out_rd),
    .ovf_count(s_ovf_count)
  );

  typedef struct {
    logic [31:0] rs1, rs2, imm, mem, wb;
    logic        src;
    logic [1:0]  op;
    logic [5:0]  fn;
    logic [1:0]  fa, fb;
    logic [4:0]  rd;
    logic [31:0] res;
    logic        z, ov, ill;
  } vec_t;

  vec_t vecs[16];

  int vectors = 0;
  int miscompares = 0;

  // Reference state
  logic        m_valid;
  logic [31:0] m_result;
  logic        m_zero, m_ovf, m_ill;
  logic [4:0]  m_rd;
  int          m_total;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic void ref_op(input logic [31:0] a, input logic [31:0] b,
                                 input logic [1:0] op, input logic [5:0] fn,
                                 output logic [31:0] r, output logic ov, output logic ill);
    longint sa, sb, s;
    sa  = longint'($signed(a));
    sb  = longint'($signed(b));
    s   = 0;
    ov  = 1'b0;
    ill = 1'b0;
    r   = 32'd0;
    if (op == 2'b00 || (op == 2'b10 && fn == 6'd32)) begin
      s = sa + sb;
    end else if (op == 2'b01 || (op == 2'b10 && fn == 6'd34)) begin
      s = sa - sb;
    end else if (op == 2'b11 || (op == 2'b10 && fn == 6'd37)) begin
      r = a | b;
    end else if (fn == 6'd36) begin
      r = a & b;
    end else if (fn == 6'd39) begin
      r = ~(a | b);
    end else if (fn == 6'd42) begin
      r = (sa < sb) ? 32'd1 : 32'd0;
    end else begin
      ill = 1'b1;
      s   = sa + sb;
    end
    if (op == 2'b00 || op == 2'b01 ||
        (op == 2'b10 && (fn == 6'd32 || fn == 6'd34 || ill))) begin
      r  = s[31:0];
      ov = (s > 64'sd2147483647) || (s < -64'sd2147483648);
    end
  endfunction

  function automatic logic [31:0] sat(input int total, input int maxv);
    return (total > maxv) ? 32'(maxv) : 32'(total);
  endfunction

  task automatic check_outputs();
    check("out_valid", 32'(out_valid), 32'(m_valid));
    check("out_result", out_result, m_result);
    check("out_zero", 32'(out_zero), 32'(m_zero));
    check("out_overflow", 32'(out_overflow), 32'(m_ovf));
    check("out_illegal", 32'(out_illegal), 32'(m_ill));
    check("out_rd", 32'(out_rd), 32'(m_rd));
    check("ovf_count", 32'(ovf_count), sat(m_total, 65535));
    check("sat_out_valid", 32'(s_out_valid), 32'(m_valid));
    check("sat_ovf_count", 32'(s_ovf_count), sat(m_total, 3));
  endtask

  task automatic model_reset();
    m_valid  = 1'b0;
    m_result = '0;
    m_zero   = 1'b0;
    m_ovf    = 1'b0;
    m_ill    = 1'b0;
    m_rd     = '0;
    m_total  = 0;
  endtask

  task automatic step();
    logic [31:0] a, b, r;
    logic        ov, ill, exp_rdy, acc;
    #2;
    exp_rdy = !m_valid || out_ready;
    check("in_ready", 32'(in_ready), 32'(exp_rdy));
    a = (fwd_a == 2'b01) ? mem_fwd : (fwd_a == 2'b10) ? wb_fwd : rs1_data;
    b = (fwd_b == 2'b01) ? mem_fwd : (fwd_b == 2'b10) ? wb_fwd : rs2_data;
    if (alu_src) b = imm;
    ref_op(a, b, alu_op, funct, r, ov, ill);
    acc = in_valid && exp_rdy && !flush;
    @(posedge clk);
    #1;
    if (flush) m_valid = 1'b0;
    else if (acc) m_valid = 1'b1;
    else if (out_ready) m_valid = 1'b0;
    if (acc) begin
      m_result = r;
      m_zero   = (r == 32'd0);
      m_ovf    = ov;
      m_ill    = ill;
      m_rd     = rd;
      if (ov) m_total++;
    end
    check_outputs();
  endtask

  task automatic drive(input vec_t v);
    rs1_data = v.rs1; rs2_data = v.rs2; imm = v.imm; mem_fwd = v.mem; wb_fwd = v.wb;
    alu_src  = v.src; alu_op = v.op; funct = v.fn; fwd_a = v.fa; fwd_b = v.fb; rd = v.rd;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    #1;
    model_reset();
    check_outputs();
    @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  task automatic drive_random();
    logic [5:0] fns[7];
    logic [31:0] corner[4];
    fns    = '{6'b100000, 6'b100010, 6'b100100, 6'b100101, 6'b101010, 6'b100111, 6'b000000};
    corner = '{32'h8000_0000, 32'h7FFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0001};
    in_valid  = ($urandom_range(3) != 0);
    out_ready = ($urandom_range(4) > 1);
    flush     = ($urandom_range(15) == 0);
    rs1_data  = ($urandom_range(3) == 0) ? corner[$urandom_range(3)] : $urandom;
    rs2_data  = ($urandom_range(3) == 0) ? corner[$urandom_range(3)] : $urandom;
    imm       = $urandom;
    mem_fwd   = $urandom;
    wb_fwd    = $urandom;
    alu_src   = 1'($urandom_range(1));
    alu_op    = 2'($urandom_range(3));
    funct     = ($urandom_range(5) == 0) ? 6'($urandom) : fns[$urandom_range(6)];
    fwd_a     = 2'($urandom_range(3));
    fwd_b     = 2'($urandom_range(3));
    rd        = 5'($urandom);
  endtask

  int flush_total;

  initial begin
    // rs1, rs2, imm, mem, wb, src, op, fn, fa, fb, rd, res, z, ov, ill
    vecs[0]  = '{32'd5, 32'd7, 0, 0, 0, 0, 2'b10, 6'b100000, 0, 0, 5'd1, 32'd12, 0, 0, 0};
    vecs[1]  = '{32'h8000_0000, 32'd1, 0, 0, 0, 0, 2'b01, 0, 0, 0, 5'd2,
                 32'h7FFF_FFFF, 0, 1, 0};
    vecs[2]  = '{32'hFFFF_FFFF, 32'd1, 0, 0, 0, 0, 2'b10, 6'b101010, 0, 0, 5'd3,
                 32'd1, 0, 0, 0};
    vecs[3]  = '{32'd123, 32'd55, 32'd9, 32'd9, 0, 1, 2'b01, 0, 2'b01, 0, 5'd4,
                 32'd0, 1, 0, 0};
    vecs[4]  = '{32'd3, 32'd4, 0, 0, 0, 0, 2'b10, 6'b000000, 0, 0, 5'd5, 32'd7, 0, 0, 1};
    vecs[5]  = '{32'hF0F0_F0F0, 32'h0FF0_0FF0, 0, 0, 0, 0, 2'b10, 6'b100100, 0, 0, 5'd6,
                 32'h00F0_00F0, 0, 0, 0};
    vecs[6]  = '{32'hF0F0_F0F0, 32'h0FF0_0FF0, 0, 0, 0, 0, 2'b10, 6'b100101, 0, 0, 5'd7,
                 32'hFFF0_FFF0, 0, 0, 0};
    vecs[7]  = '{32'hF0F0_F0F0, 32'h0FF0_0FF0, 0, 0, 0, 0, 2'b10, 6'b100111, 0, 0, 5'd8,
                 32'h000F_000F, 0, 0, 0};
    vecs[8]  = '{32'h1234_0000, 32'd0, 32'h0000_FFFF, 0, 0, 1, 2'b11, 0, 0, 0, 5'd9,
                 32'h1234_FFFF, 0, 0, 0};
    vecs[9]  = '{32'd20, 32'd999, 0, 0, 32'd100, 0, 2'b00, 0, 0, 2'b10, 5'd10,
                 32'd120, 0, 0, 0};
    vecs[10] = '{32'd16, 32'd0, 32'hFFFF_FFFC, 32'd777, 0, 1, 2'b00, 0, 0, 2'b01, 5'd11,
                 32'd12, 0, 0, 0};
    vecs[11] = '{32'h7FFF_FFFF, 32'd1, 0, 0, 0, 0, 2'b10, 6'b100000, 0, 0, 5'd12,
                 32'h8000_0000, 0, 1, 0};
    vecs[12] = '{32'h8000_0000, 32'h8000_0000, 0, 0, 0, 0, 2'b00, 0, 0, 0, 5'd13,
                 32'd0, 1, 1, 0};
    vecs[13] = '{32'h8000_0000, 32'd1, 0, 0, 0, 0, 2'b10, 6'b101010, 0, 0, 5'd14,
                 32'd1, 0, 0, 0};
    vecs[14] = '{32'h8000_0000, 32'd1, 0, 0, 0, 0, 2'b10, 6'b100010, 0, 0, 5'd15,
                 32'h7FFF_FFFF, 0, 1, 0};
    vecs[15] = '{32'd10, 32'd3, 0, 32'hDEAD, 32'hDEAD, 0, 2'b10, 6'b100010, 2'b11, 2'b11,
                 5'd31, 32'd7, 0, 0, 0};

    in_valid = 1'b0; out_ready = 1'b1; flush = 1'b0;
    drive(vecs[0]);
    do_reset();

    // Directed table, one op per cycle with the sink always ready.
    in_valid = 1'b1;
    for (int i = 0; i < 16; i++) begin
      drive(vecs[i]);
      step();
      check($sformatf("vec%0d_result", i), out_result, vecs[i].res);
      check($sformatf("vec%0d_zero", i), 32'(out_zero), 32'(vecs[i].z));
      check($sformatf("vec%0d_ovf", i), 32'(out_overflow), 32'(vecs[i].ov));
      check($sformatf("vec%0d_illegal", i), 32'(out_illegal), 32'(vecs[i].ill));
      if (i == 1) check("first_ovf_count", 32'(ovf_count), 32'd1);
    end
    check("table_ovf_count", 32'(ovf_count), 32'd4);
    check("table_sat_count", 32'(s_ovf_count), 32'd3);
    in_valid = 1'b0;
    step();

    // Backpressure: hold the first result while the sink stalls.
    drive(vecs[0]);
    rs1_data = 32'd1; rs2_data = 32'd2;
    in_valid = 1'b1; out_ready = 1'b0;
    step();
    rs1_data = 32'd10; rs2_data = 32'd20;
    for (int i = 0; i < 3; i++) begin
      step();
      check("bp_in_ready_low", 32'(in_ready), 32'd0);
      check("bp_result_held", out_result, 32'd3);
    end
    out_ready = 1'b1;
    step();
    check("bp_next_result", out_result, 32'd30);

    // Flush with an overflowing op in the same cycle.
    drive(vecs[1]);
    flush_total = m_total;
    flush = 1'b1;
    step();
    check("flush_valid", 32'(out_valid), 32'd0);
    check("flush_count", 32'(ovf_count), 32'(flush_total));
    flush = 1'b0;

    for (int i = 0; i < 400; i++) begin
      drive_random();
      step();
    end

    // Reset mid-stream with a valid result and two counted overflows.
    in_valid = 1'b0; out_ready = 1'b1; flush = 1'b0;
    do_reset();
    drive(vecs[1]);
    in_valid = 1'b1;
    step();
    step();
    in_valid = 1'b0; out_ready = 1'b0;
    step();
    check("pre_reset_valid", 32'(out_valid), 32'd1);
    check("pre_reset_count", 32'(ovf_count), 32'd2);
    #2;
    rst_n = 1'b0;
    #1;
    check("async_valid", 32'(out_valid), 32'd0);
    check("async_result", out_result, 32'd0);
    check("async_flags", {29'd0, out_zero, out_overflow, out_illegal}, 32'd0);
    check("async_rd", 32'(out_rd), 32'd0);
    check("async_count", 32'(ovf_count), 32'd0);
    model_reset();
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    check_outputs();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/alu_ex_stage.md
# alu_ex_stage

Pipelined execute stage wrapping the 32-bit ALU. It sits between the ID/EX boundary and the EX/MEM boundary and performs four jobs: operand forwarding selection, immediate muxing, decode of `alu_op`/`funct` into the 4-bit ALU control, and registering the ALU outputs behind a valid/ready handshake. It also keeps a saturating count of arithmetic overflows for debug.

## Interface
Parameters:
- `CNT_W`, default 16: width of the overflow counter.

Ports:
- `clk`: input, 1 bit. The single clock; all state updates on its rising edge.
- `rst_n`: input, 1 bit. Asynchronous, active-low reset.
- `in_valid`: input, 1 bit. Upstream presents an operation.
- `in_ready`: output, 1 bit. The stage can accept an operation.
- `rs1_data`, `rs2_data`: input, 32 bits each. Register-file operands.
- `imm`: input, 32 bits. Sign-extended immediate.
- `alu_src`: input, 1 bit. 1 selects `imm` as operand B.
- `alu_op`: input, 2 bits. 00 = add (lw/sw), 01 = sub (beq), 10 = R-type (decode `funct`), 11 = or (ori).
- `funct`: input, 6 bits. R-type function field.
- `rd`: input, 5 bits. Destination register, passed through.
- `fwd_a`, `fwd_b`: input, 2 bits each. 00 = register file, 01 = `mem_fwd`, 10 = `wb_fwd`, 11 = register file.
- `mem_fwd`, `wb_fwd`: input, 32 bits each. Forwarded values.
- `flush`: input, 1 bit. Kills the registered output.
- `out_valid`: output, 1 bit. The registered result is valid.
- `out_ready`: input, 1 bit. Downstream accepts the result.
- `out_result`: output, 32 bits. Registered ALU result.
- `out_zero`: output, 1 bit. Registered zero flag.
- `out_overflow`: output, 1 bit. Registered overflow flag, masked to add/sub.
- `out_illegal`: output, 1 bit. Unknown R-type `funct`.
- `out_rd`: output, 5 bits. Registered `rd`.
- `ovf_count`: output, `CNT_W` bits. Saturating overflow counter.

## Operation
- **Operand A:** chosen by `fwd_a`.
- **Operand B:** first the `fwd_b` selection is made; `alu_src` = 1 then overrides it with `imm`. Forwarding never applies to `imm`.
- **ALU control decode:**
  - `alu_op` 00 → 0010 (add)
  - `alu_op` 01 → 0110 (sub)
  - `alu_op` 11 → 0001 (or)
  - `alu_op` 10 with `funct` 100000 → 0010 (add), 100010 → 0110 (sub), 100100 → 0000 (and), 100101 → 0001 (or), 101010 → 0111 (slt), 100111 → 1100 (nor)
  - any other `funct` under `alu_op` 10 → control 0010 and `out_illegal` = 1
- **ALU behaviour:** the ALU is purely combinational and is instantiated unchanged. Its `zero` output reflects the final result, including slt. SLT is signed and uses the subtraction's set bit.
- **Overflow masking:** `out_overflow` = ALU overflow only when the control is 0010 or 0110; otherwise 0. This includes slt, whose internal subtraction overflow is not reported.
- **Output register:** a single entry holding `out_result`, `out_zero`, `out_overflow`, `out_illegal` and `out_rd`.
- **Ready:** `in_ready = !out_valid || out_ready`.
- **Accept:** occurs when `in_valid && in_ready && !flush`. On accept the entry loads the ALU outputs and `out_valid` goes to 1.
- **Drain:** when `out_valid && out_ready` and no new accept, `out_valid` goes to 0. The payload registers hold their last value.
- **Flush:** `out_valid` goes to 0 on the next edge. Any input presented in the same cycle is dropped and not counted. `in_ready` is not gated by `flush`.
- **Overflow counter:** `ovf_count` increments by 1 on each accept whose masked overflow is 1. It saturates at all-ones, and only reset clears it.

## Timing
- **Reset:** asserting `rst_n` low immediately clears `out_valid`, `out_result`, `out_zero`, `out_overflow`, `out_illegal`, `out_rd` and `ovf_count` to 0. An operation in flight is lost.
- **Latency:** an op accepted at edge N has its result visible with `out_valid` = 1 after edge N.
- **Throughput:** one op per cycle when `out_ready` is held high. Simultaneous drain and accept keeps `out_valid` = 1 with the new payload.
- **Backpressure:** while `out_valid && !out_ready`, `in_ready` = 0 and all outputs are held stable.
- **Combinational paths:** the only combinational path from input to output is `out_ready` → `in_ready`. All other outputs are registered.

## Test plan
- **Basic R-type add:** after reset, `alu_op` = 10, `funct` = 100000, `rs1` = 5, `rs2` = 7, `fwd` = 00 → one cycle later `out_valid` = 1, `out_result` = 12, `out_zero` = 0, `out_overflow` = 0.
- **Overflow and saturation:**
  - sub with `rs1` = 0x80000000, `rs2` = 1 → `out_result` = 0x7FFFFFFF, `out_overflow` = 1, `ovf_count` = 1.
  - with `CNT_W` = 2, four overflowing ops → `ovf_count` stays at 3.
- **SLT and forwarding:**
  - slt with `rs1` = 0xFFFFFFFF, `rs2` = 1 → `out_result` = 1, `out_zero` = 0.
  - `fwd_a` = 01, `mem_fwd` = 9, `alu_src` = 1, `imm` = 9, `alu_op` = 01 → `out_result` = 0, `out_zero` = 1.
- **Backpressure:**
  - `out_ready` = 0 for 3 cycles with `in_valid` held → `in_ready` = 0 and the first result is held unchanged.
  - raising `out_ready` → the next op is accepted in that same cycle.
- **Flush and illegal funct:**
  - `flush` asserted together with a valid input → `out_valid` = 0 next cycle and `ovf_count` unchanged.
  - `funct` = 000000 under `alu_op` 10 → `out_illegal` = 1 and the result equals the add of the operands.
- **Reset mid-stream:** drop `rst_n` while `out_valid` = 1 and `ovf_count` = 2 → all outputs read 0 immediately, without waiting for a clock edge.
